// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Package  : matmul_pkg
// Desc     : Shared width helpers and tile geometry for the parallel matrix
//            multiplier (multiplier top, row_col_multiplier tiles, writeback).
// Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

  localparam int c_data_w = 32;
  localparam int c_base_w = 16;

  // Row and column base of a tile inside the result matrix.
  typedef struct packed {
    logic [c_base_w-1:0] row;
    logic [c_base_w-1:0] col;
  } tile_base_t;

  // Integer ceiling division, used for the tiles-per-side count.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Index width that stays at least one bit wide for trivial ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Requester k owns tile row k/t and tile column k%t; each tile is m wide.
  function automatic tile_base_t tile_base(input int k, input int t, input int m);
    tile_base_t b;
    b.row = c_base_w'((k / t) * m);
    b.col = c_base_w'((k % t) * m);
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Desc     : Combinational round-robin picker. Searches upward from ptr+1
//            with wrap-around and returns a one-hot grant and winner index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
  parameter int N_REQ = 9,
  parameter int PTR_W = 4
) (
  input  logic [N_REQ-1:0] i_eligible,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PTR_W-1:0] o_winner,
  output logic             o_valid
);

  logic [PTR_W-1:0] w_idx;

  // First eligible requester after the pointer wins; the pointer itself is last.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % N_REQ);
      if (!o_valid && i_eligible[w_idx]) begin
        o_valid         = 1'b1;
        o_winner        = w_idx;
        o_grant[w_idx]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : result_writeback_arbiter
// Desc     : Shares the single R write port among tile multipliers. Grants
//            round-robin, translates tile-local indices to absolute R
//            coordinates, issues one registered write per cycle, counts
//            completed writes and flags completion, bad addresses, overflow.
// Revision : 1.0 - initial release
// ============================================================================
module result_writeback_arbiter
  import matmul_pkg::*;
#(
  parameter int N     = 10,
  parameter int M     = 4,
  parameter int T     = ceil_div(N, M),
  parameter int N_REQ = T * T,
  parameter int IDX_W = idx_width(N),
  parameter int LOC_W = idx_width(M)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_REQ-1:0]          req_stb,
  input  logic [N_REQ*LOC_W-1:0]    req_i,
  input  logic [N_REQ*LOC_W-1:0]    req_j,
  input  logic [N_REQ*c_data_w-1:0] req_data,
  output logic [N_REQ-1:0]          req_ack,
  output logic                      wr_en,
  output logic [IDX_W-1:0]          wr_row,
  output logic [IDX_W-1:0]          wr_col,
  output logic [c_data_w-1:0]       wr_data,
  output logic                      all_done,
  output logic                      addr_err,
  output logic                      overflow
);

  localparam int c_ptr_w = idx_width(N_REQ);
  localparam int c_cnt_w = $clog2(N * N + 1);
  // One extra bit so an edge-tile address cannot wrap below N before the check.
  localparam int c_aw    = IDX_W + 1;

  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(N * N);
  localparam logic [c_ptr_w-1:0] c_ptr_init = c_ptr_w'(N_REQ - 1);
  localparam logic [c_aw-1:0]    c_n        = c_aw'(N);

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  logic [c_ptr_w-1:0]    r_ptr;
  logic [N_REQ-1:0]      r_ack;
  logic                  r_wr_en;
  logic [IDX_W-1:0]      r_wr_row;
  logic [IDX_W-1:0]      r_wr_col;
  logic [c_data_w-1:0]   r_wr_data;
  logic [c_cnt_w-1:0]    r_count;
  logic                  r_all_done;
  logic                  r_addr_err;
  logic                  r_overflow;

  logic [N_REQ-1:0]      w_eligible;
  logic [N_REQ-1:0]      w_grant;
  logic [c_ptr_w-1:0]    w_winner;
  logic                  w_valid;
  logic [c_aw-1:0]       w_row    [N_REQ];
  logic [c_aw-1:0]       w_col    [N_REQ];
  logic [N_REQ-1:0]      w_in_range;
  logic [IDX_W-1:0]      w_sel_row;
  logic [IDX_W-1:0]      w_sel_col;
  logic [c_data_w-1:0]   w_sel_data;
  logic                  w_sel_ok;

  // Assertion is immediate; release reaches the datapath two edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // A requester still being acknowledged is masked to avoid a double grant.
  assign w_eligible = req_stb & ~r_ack;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .PTR_W (c_ptr_w)
  ) u_picker (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_winner   (w_winner),
    .o_valid    (w_valid)
  );

  for (genvar k = 0; k < N_REQ; k++) begin : g_xlate
    localparam tile_base_t c_base = tile_base(k, T, M);
    assign w_row[k]      = c_base.row[c_aw-1:0] + c_aw'(req_i[k*LOC_W +: LOC_W]);
    assign w_col[k]      = c_base.col[c_aw-1:0] + c_aw'(req_j[k*LOC_W +: LOC_W]);
    assign w_in_range[k] = (w_row[k] < c_n) && (w_col[k] < c_n);
  end

  // Steer the winning requester's address, data and range verdict.
  always_comb begin
    w_sel_row  = '0;
    w_sel_col  = '0;
    w_sel_data = '0;
    w_sel_ok   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_row  = w_row[k][IDX_W-1:0];
        w_sel_col  = w_col[k][IDX_W-1:0];
        w_sel_data = req_data[k*c_data_w +: c_data_w];
        w_sel_ok   = w_in_range[k];
      end
    end
  end

  // Pointer, write port, completion counter and sticky flags.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ptr      <= c_ptr_init;
      r_ack      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_row   <= '0;
      r_wr_col   <= '0;
      r_wr_data  <= '0;
      r_count    <= '0;
      r_all_done <= 1'b0;
      r_addr_err <= 1'b0;
      r_overflow <= 1'b0;
    end else if (start) begin
      r_ptr      <= c_ptr_init;
      r_ack      <= '0;
      r_wr_en    <= 1'b0;
      r_count    <= '0;
      r_all_done <= 1'b0;
      r_addr_err <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_all_done <= (r_count == c_full);
      r_ack      <= w_grant;
      r_wr_en    <= 1'b0;
      if (w_valid) begin
        r_ptr <= w_winner;
        if (w_sel_ok) begin
          r_wr_en   <= 1'b1;
          r_wr_row  <= w_sel_row;
          r_wr_col  <= w_sel_col;
          r_wr_data <= w_sel_data;
          // The write still happens once full; the counter just saturates.
          if (r_count == c_full) r_overflow <= 1'b1;
          else                   r_count    <= r_count + c_cnt_w'(1);
        end else begin
          r_addr_err <= 1'b1;
        end
      end
    end
  end

  assign req_ack  = r_ack;
  assign wr_en    = r_wr_en;
  assign wr_row   = r_wr_row;
  assign wr_col   = r_wr_col;
  assign wr_data  = r_wr_data;
  assign all_done = r_all_done;
  assign addr_err = r_addr_err;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_result_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_writeback_arbiter
// Desc     : Self-checking bench for result_writeback_arbiter (N=10, M=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_writeback_arbiter;

  localparam int N  = 10;
  localparam int M  = 4;
  localparam int T  = 3;
  localparam int NR = 9;
  localparam int LW = 2;
  localparam int IW = 4;
  localparam int NN = N * N;

  typedef struct packed {
    logic [1:0]  i;
    logic [1:0]  j;
    logic [31:0] d;
  } elem_t;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             start    = 1'b0;
  logic [NR-1:0]    req_stb  = '0;
  logic [NR*LW-1:0] req_i    = '0;
  logic [NR*LW-1:0] req_j    = '0;
  logic [NR*32-1:0] req_data = '0;
  logic [NR-1:0]    req_ack;
  logic             wr_en;
  logic [IW-1:0]    wr_row;
  logic [IW-1:0]    wr_col;
  logic [31:0]      wr_data;
  logic             all_done;
  logic             addr_err;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  elem_t q[NR][$];
  int    ack_log[$];

  // Reference model state.
  logic [NR-1:0] m_ack;
  logic          m_wr_en;
  logic [IW-1:0] m_row;
  logic [IW-1:0] m_col;
  logic [31:0]   m_data;
  int            m_count;
  int            m_ptr;
  int            m_sync;
  logic          m_done;
  logic          m_aerr;
  logic          m_ovf;

  result_writeback_arbiter #(.N(N), .M(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .req_stb  (req_stb),
    .req_i    (req_i),
    .req_j    (req_j),
    .req_data (req_data),
    .req_ack  (req_ack),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .all_done (all_done),
    .addr_err (addr_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic elem_t mk(input int i, input int j, input logic [31:0] d);
    elem_t e;
    e.i = 2'(i);
    e.j = 2'(j);
    e.d = d;
    return e;
  endfunction

  task automatic model_reset();
    m_ack = '0; m_wr_en = 1'b0; m_row = '0; m_col = '0; m_data = '0;
    m_count = 0; m_ptr = NR - 1; m_done = 1'b0; m_aerr = 1'b0; m_ovf = 1'b0;
  endtask

  function automatic logic busy();
    for (int k = 0; k < NR; k++) if (q[k].size() != 0) return 1'b1;
    return (m_ack != '0);
  endfunction

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      if (q[k].size() > 0) begin
        req_stb[k]            = 1'b1;
        req_i[k*LW +: LW]     = q[k][0].i;
        req_j[k*LW +: LW]     = q[k][0].j;
        req_data[k*32 +: 32]  = q[k][0].d;
      end else begin
        req_stb[k] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("ack",      64'(req_ack),  64'(m_ack));
    chk("wr_en",    64'(wr_en),    64'(m_wr_en));
    chk("wr_row",   64'(wr_row),   64'(m_row));
    chk("wr_col",   64'(wr_col),   64'(m_col));
    chk("wr_data",  64'(wr_data),  64'(m_data));
    chk("all_done", 64'(all_done), 64'(m_done));
    chk("addr_err", 64'(addr_err), 64'(m_aerr));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    for (int k = 0; k < NR; k++) if (req_ack[k]) ack_log.push_back(k);
  endtask

  // Predict the next edge from the rules, clock, compare, then let requesters react.
  task automatic tick();
    int win;
    int r;
    int c;
    logic nd;
    win = -1;
    if (!rst) begin
      m_sync = 0;
      model_reset();
    end else if (m_sync < 2) begin
      m_sync++;
      model_reset();
    end else if (start) begin
      m_ack = '0; m_wr_en = 1'b0; m_count = 0; m_ptr = NR - 1;
      m_done = 1'b0; m_aerr = 1'b0; m_ovf = 1'b0;
    end else begin
      for (int off = 1; off <= NR; off++) begin
        int k;
        k = (m_ptr + off) % NR;
        if (win < 0 && req_stb[k] && !m_ack[k]) win = k;
      end
      nd = (m_count == NN);
      m_ack   = '0;
      m_wr_en = 1'b0;
      if (win >= 0) begin
        m_ack[win] = 1'b1;
        m_ptr      = win;
        r = (win / T) * M + int'(req_i[win*LW +: LW]);
        c = (win % T) * M + int'(req_j[win*LW +: LW]);
        if (r < N && c < N) begin
          m_wr_en = 1'b1;
          m_row   = IW'(r);
          m_col   = IW'(c);
          m_data  = req_data[win*32 +: 32];
          if (m_count == NN) m_ovf = 1'b1;
          else               m_count++;
        end else begin
          m_aerr = 1'b1;
        end
      end
      m_done = nd;
    end
    @(posedge clk);
    #1;
    check_outputs();
    for (int k = 0; k < NR; k++) if (m_ack[k] && q[k].size() > 0) void'(q[k].pop_front());
    drive();
  endtask

  task automatic run_idle();
    int g;
    g = 0;
    while (busy() && g < 1000) begin
      tick();
      g++;
    end
    chk("idle_timeout", 64'(busy()), 64'(0));
  endtask

  initial begin
    int exp_rr[3];
    int g;
    exp_rr[0] = 0; exp_rr[1] = 3; exp_rr[2] = 8;
    model_reset();
    m_sync = 0;

    // Reset state.
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",      64'(req_ack),  64'(0));
    chk("rst_wr_en",    64'(wr_en),    64'(0));
    chk("rst_wr_row",   64'(wr_row),   64'(0));
    chk("rst_wr_col",   64'(wr_col),   64'(0));
    chk("rst_wr_data",  64'(wr_data),  64'(0));
    chk("rst_all_done", 64'(all_done), 64'(0));
    chk("rst_addr_err", 64'(addr_err), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    @(negedge clk) rst = 1'b1;

    // Single request: tile (1,1) local (2,3) -> R(6,7).
    q[4].push_back(mk(2, 3, 32'hDEADBEEF));
    drive();
    run_idle();
    tick();
    chk("single_row",  64'(wr_row),  64'(6));
    chk("single_col",  64'(wr_col),  64'(7));
    chk("single_data", 64'(wr_data), 64'hDEADBEEF);
    chk("single_aerr", 64'(addr_err), 64'(0));

    // Edge tile: tile (2,2) local row 3 -> row 11, out of range.
    ack_log.delete();
    q[8].push_back(mk(3, 0, $urandom));
    drive();
    run_idle();
    chk("edge_aerr",     64'(addr_err),        64'(1));
    chk("edge_ack_seen", 64'(ack_log.size()),  64'(1));
    chk("edge_row_held", 64'(wr_row),          64'(6));

    // Round-robin among requesters 0, 3 and 8.
    start = 1'b1; tick(); start = 1'b0;
    ack_log.delete();
    for (int n = 0; n < 4; n++) begin
      q[0].push_back(mk(n % 4, n / 2, $urandom));
      q[3].push_back(mk(n % 4, (n + 1) % 4, $urandom));
      q[8].push_back(mk(n % 2, n / 2, $urandom));
    end
    drive();
    run_idle();
    for (int x = 0; x < 12; x++) chk("rr_order", 64'(ack_log[x]), 64'(exp_rr[x % 3]));

    // Full run: all 100 elements in shuffled per-tile order, with bad addresses mixed in.
    start = 1'b1; tick(); start = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        q[(r / M) * T + (c / M)].push_back(mk(r % M, c % M, $urandom));
    for (int k = 0; k < NR; k++) begin
      for (int a = q[k].size() - 1; a > 0; a--) begin
        int b;
        elem_t t;
        b = int'($urandom_range(0, a));
        t = q[k][a]; q[k][a] = q[k][b]; q[k][b] = t;
      end
      if ((k / T) == T - 1 || (k % T) == T - 1)
        q[k].insert(int'($urandom_range(0, q[k].size())), mk(3, 3, $urandom));
    end
    drive();
    run_idle();
    repeat (3) tick();
    chk("full_done", 64'(all_done), 64'(1));
    chk("full_ovf",  64'(overflow), 64'(0));
    chk("full_aerr", 64'(addr_err), 64'(1));
    q[0].push_back(mk(1, 1, $urandom));
    drive();
    run_idle();
    repeat (2) tick();
    chk("extra_ovf",  64'(overflow), 64'(1));
    chk("extra_done", 64'(all_done), 64'(1));

    // start while strobes are pending.
    q[5].push_back(mk(0, 1, $urandom));
    q[7].push_back(mk(1, 0, $urandom));
    q[2].push_back(mk(1, 1, $urandom));
    drive();
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ack",  64'(req_ack),  64'(0));
    chk("start_wren", 64'(wr_en),    64'(0));
    chk("start_done", 64'(all_done), 64'(0));
    chk("start_ovf",  64'(overflow), 64'(0));
    ack_log.delete();
    run_idle();
    chk("start_first", 64'(ack_log[0]), 64'(2));

    // Asynchronous reset in a cycle with wr_en high.
    for (int n = 0; n < 3; n++) begin
      q[5].push_back(mk(n, 2, $urandom));
      q[0].push_back(mk(2, n, $urandom));
    end
    q[7].push_back(mk(0, 3, $urandom));
    drive();
    g = 0;
    do begin
      tick();
      g++;
    end while (!m_wr_en && g < 20);
    chk("arst_wr_en_before", 64'(wr_en), 64'(1));
    #1 rst = 1'b0;
    #1;
    chk("arst_ack",      64'(req_ack),  64'(0));
    chk("arst_wr_en",    64'(wr_en),    64'(0));
    chk("arst_wr_row",   64'(wr_row),   64'(0));
    chk("arst_wr_col",   64'(wr_col),   64'(0));
    chk("arst_wr_data",  64'(wr_data),  64'(0));
    chk("arst_all_done", 64'(all_done), 64'(0));
    chk("arst_addr_err", 64'(addr_err), 64'(0));
    chk("arst_overflow", 64'(overflow), 64'(0));
    m_sync = 0;
    model_reset();
    @(negedge clk) rst = 1'b1;
    ack_log.delete();
    run_idle();
    chk("arst_first", 64'(ack_log[0]), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_writeback_arbiter.md
# result_writeback_arbiter

Shares the single write port of the result matrix `R` among the tile multipliers of the parallel matrix multiplier, one tile per requester. Each tile raises a strobe with a tile-local element index and a 32-bit value. The arbiter grants requesters round-robin, translates the tile-local index to an absolute `R` row and column, issues one registered write per cycle, and returns a one-cycle acknowledge. It also counts completed writes and raises `all_done` when the whole `N×N` result has been written.

## Interface
Parameters:
- `N`, default 10: matrix dimension.
- `M`, default 4: tile dimension.
- `T`, default `ceil(N/M)`: tiles per row and per column.
- `N_REQ`, default `T*T`: number of requesters; requester `k` owns tile row `k/T`, tile column `k%T`.
- `IDX_W`, default `clog2(N)`: width of an absolute index.
- `LOC_W`, default `clog2(M)`: width of a tile-local index.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: synchronous clear of the write counter, flags and round-robin pointer.
- `req_stb`, in, `N_REQ`: per-requester write strobe. The requester holds it until acknowledged.
- `req_i`, in, `N_REQ*LOC_W`: flattened tile-local row indices.
- `req_j`, in, `N_REQ*LOC_W`: flattened tile-local column indices.
- `req_data`, in, `N_REQ*32`: flattened write data.
- `req_ack`, out, `N_REQ`: one-cycle acknowledge per requester.
- `wr_en`, out, 1: `R` write enable.
- `wr_row`, out, `IDX_W`: absolute row.
- `wr_col`, out, `IDX_W`: absolute column.
- `wr_data`, out, 32: write value.
- `all_done`, out, 1: `N*N` valid writes completed.
- `addr_err`, out, 1: sticky; set when a request maps outside the `N×N` range.
- `overflow`, out, 1: sticky; set when a valid write arrives after `all_done`.

## Operation
**Eligibility.** Requester `k` is eligible in a cycle when `req_stb[k]=1` and `req_ack[k]=0`. Masking on `req_ack` prevents a double grant while the requester is still dropping its strobe.

**Arbitration.**
- Round-robin, searching from `ptr+1` upward with wrap-around at `N_REQ`.
- At most one grant per cycle.
- `ptr` is updated to the index of the winner.
- After reset and after `start`, `ptr = N_REQ-1`, so requester 0 has top priority.

**Address translation.** Both values are computed at full `IDX_W+1` width, so no silent wrap occurs before the range check.
- `row = (k/T)*M + req_i[k]`
- `col = (k%T)*M + req_j[k]`

**Valid write.** When `row<N` and `col<N`:
- `wr_en`, `wr_row`, `wr_col` and `wr_data` are registered.
- `wr_count` increments.

**Invalid address.** When `row>=N` or `col>=N` (edge tiles when `N%M≠0`):
- No write is issued and the counter does not change.
- `addr_err` is set.
- `req_ack` is still returned, so the requester never deadlocks.

**Completion counter.**
- Width `clog2(N*N+1)`.
- `all_done` is the registered value of `wr_count==N*N`.
- After `all_done`, a further valid write is still performed, `overflow` is set, and the counter saturates at `N*N`.

**`start`.**
- Clears `wr_count`, `all_done`, `addr_err`, `overflow` and `ptr`.
- No grant is issued in the `start` cycle; `req_ack` and `wr_en` are 0 in the following cycle.

**Reset.** Asynchronous assertion clears every register immediately, including mid-write: all outputs go to 0 and `ptr` goes to `N_REQ-1`. Deassertion is synchronized to `clk`.

## Timing
- Grant decision is combinational in cycle t. `req_ack[k]` and `wr_*` are valid for exactly cycle t+1.
- `wr_en` is a single-cycle pulse per grant; `wr_*` holds its last value when `wr_en=0`.
- Requester protocol: deassert `req_stb` or present the next element no later than cycle t+2.
- Throughput: one write per cycle when two or more requesters are eligible. A single requester alone gets at most one write every 2 cycles.
- Fairness: an eligible requester is granted within `N_REQ` cycles.
- `all_done` rises one cycle after the `wr_en` of the final write; that is 2 cycles after the final grant decision.
- Reset values: `req_ack=0`, `wr_en=0`, `wr_row=0`, `wr_col=0`, `wr_data=0`, `all_done=0`, `addr_err=0`, `overflow=0`.

## Structure
- Shared package `matmul_pkg`:
  - `clog2`-based width constants and the `T` computation.
  - A function `tile_base(k)` returning the tile's row and column base.
  - Reused by the multiplier top and the `row_col_multiplier` tiles.
- Sub-module `rr_priority_picker`:
  - Input: eligible mask and `ptr`.
  - Output: one-hot grant and winner index.
  - Purely combinational, parameterized by `N_REQ`.
- The top holds the pointer, the output registers, the counter and the flags.

## Test plan
- **Single request.** `N=10`, `M=4`, `T=3`; requester 4 (tile 1,1) with `req_i=2`, `req_j=3`, `data=0xDEADBEEF` → `wr_en` for one cycle with row 6, col 7, data `0xDEADBEEF`; `req_ack[4]` for one cycle; `wr_count=1`.
- **Round-robin.** Requesters 0, 3 and 8 strobe continuously → grant order 0, 3, 8, 0, 3, 8, …; one `wr_en` every cycle; no requester starves.
- **Edge tile.** Requester 8 (tile 2,2) with `req_i=3` → row 11 is out of range → no `wr_en`, `req_ack[8]` still pulses, `addr_err=1`, counter unchanged.
- **Full run.** All 100 valid elements are written through mixed requesters → `all_done` rises 2 cycles after the final grant. One extra write afterwards → `overflow=1`, `wr_count` stays at 100.
- **`start` with pending strobes.** `start` asserted while strobes are pending → no ack or write in the following cycle; counter and flags are 0; the next grant goes to the lowest-index eligible requester.
- **Async reset mid-write.** `rst` driven low in a cycle with `wr_en=1` → all outputs are 0 immediately, before the next edge. After release, arbitration restarts from requester 0.
